button_conditioner: RTL

//  N-channel successor to the single-button debouncer; one shared clock and timing base.
//  Per channel: 2-FF synchroniser, debounce filter, press/release edge pulses,

---
 rtl/button_conditioner.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: N independent push-button conditioners sharing one clock.
// Per channel: 2-FF synchroniser -> debounce filter -> press/release pulses,
// then a small FSM that produces a long-press pulse and optional auto-repeat.
//
// Ports:
//   clk_i      system clock, every register updates on the rising edge
//   rst_i      synchronous reset, active-high
//   button_i   raw asynchronous pins, one per channel
//   level_o    debounced level, 1 = pressed
//   press_o    1-cycle pulse on the cycle level_o rises
//   release_o  1-cycle pulse on the cycle level_o falls
//   hold_o     1-cycle pulse HOLD_CYC cycles after press_o while still pressed
//   repeat_o   1-cycle pulse every RPT_CYC cycles after hold_o while still pressed
//
// Latency: a clean pin edge reaches level_o/press_o/release_o after 2 + DB_CYC cycles.
// All outputs are registered; there is no combinational path from button_i.

module button_conditioner #(
    parameter int   CLK_FREQ    = 25_000_000,
    parameter int   N_CH        = 4,
    parameter int   DEBOUNCE_MS = 10,
    parameter int   HOLD_MS     = 1000,
    parameter int   REPEAT_MS   = 200,
    parameter logic ACTIVE_LOW  = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] button_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] hold_o,
    output logic [N_CH-1:0] repeat_o
);

    // Cycle counts are computed in 64 bits: CLK_FREQ * HOLD_MS overflows 32 bits
    // for realistic clock rates before the division by 1000.
    localparam longint DB_CYC_L   = (longint'(CLK_FREQ) * longint'(DEBOUNCE_MS)) / 1000;
    localparam longint HOLD_CYC_L = (longint'(CLK_FREQ) * longint'(HOLD_MS)) / 1000;
    localparam longint RPT_CYC_L  = (longint'(CLK_FREQ) * longint'(REPEAT_MS)) / 1000;

    localparam int DB_CYC   = int'(DB_CYC_L);
    localparam int HOLD_CYC = int'(HOLD_CYC_L);
    localparam int RPT_CYC  = int'(RPT_CYC_L);

    // Clamped copies keep counter widths legal while the elaboration check fires.
    localparam int DB_CYC_S   = (DB_CYC < 1) ? 1 : DB_CYC;
    localparam int HOLD_CYC_S = (HOLD_CYC < 1) ? 1 : HOLD_CYC;
    localparam int RPT_CYC_S  = (RPT_CYC < 0) ? 0 : RPT_CYC;
    localparam int MAX_CYC    = (HOLD_CYC_S > RPT_CYC_S) ? HOLD_CYC_S : RPT_CYC_S;

    localparam int DBW = $clog2(DB_CYC_S + 1);
    localparam int HW  = $clog2(MAX_CYC + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYC_S - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYC_S - 1);
    localparam logic [HW-1:0]  RPT_LAST  = HW'((RPT_CYC_S > 0) ? RPT_CYC_S - 1 : 0);
    localparam bit             RPT_EN    = (RPT_CYC_S > 0);

    if (DB_CYC < 1) begin : g_err_db
        $error("button_conditioner: DEBOUNCE_MS gives fewer than 1 clock cycle");
    end
    if (HOLD_CYC < 1) begin : g_err_hold
        $error("button_conditioner: HOLD_MS gives fewer than 1 clock cycle");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } state_e;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch

        logic           pin_c;
        logic           sync1_q, sync2_q;
        logic [DBW-1:0] dcnt_q, dcnt_d;
        logic           level_q, level_d;
        logic           press_q, release_q;
        logic           differ, db_done, rise, fall;

        state_e         state_q;
        logic [HW-1:0]  hcnt_q;
        logic           hold_q, repeat_q;

        // Polarity is corrected before synchronising so everything downstream
        // works in "1 = pressed".
        assign pin_c = button_i[g] ^ ACTIVE_LOW;

        // The filter only counts while the synchronised value disagrees with the
        // current level; a single agreeing cycle throws the count away.
        assign differ  = (sync2_q != level_q);
        assign db_done = differ && (dcnt_q == DB_LAST);
        assign rise    = db_done &&  sync2_q;
        assign fall    = db_done && !sync2_q;

        always_comb begin
            dcnt_d  = dcnt_q;
            level_d = level_q;
            if (!differ) begin
                dcnt_d = '0;
            end else if (db_done) begin
                dcnt_d  = '0;
                level_d = sync2_q;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                sync1_q   <= 1'b0;
                sync2_q   <= 1'b0;
                dcnt_q    <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                sync1_q   <= pin_c;
                sync2_q   <= sync1_q;
                dcnt_q    <= dcnt_d;
                level_q   <= level_d;
                press_q   <= rise;
                release_q <= fall;
            end
        end

        // Hold / repeat FSM. It reacts to the same-edge rise/fall of the
        // filter, so hcnt starts counting on the cycle press_o is visible and a
        // release on the edge a hold/repeat is due suppresses that pulse.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q  <= ST_IDLE;
                hcnt_q   <= '0;
                hold_q   <= 1'b0;
                repeat_q <= 1'b0;
            end else begin
                hold_q   <= 1'b0;
                repeat_q <= 1'b0;
                case (state_q)
                    ST_IDLE: begin
                        if (rise) begin
                            hcnt_q  <= '0;
                            state_q <= ST_PRESSED;
                        end
                    end
                    ST_PRESSED: begin
                        if (fall) begin
                            hcnt_q  <= '0;
                            state_q <= ST_IDLE;
                        end else if (hcnt_q == HOLD_LAST) begin
                            hold_q  <= 1'b1;
                            hcnt_q  <= '0;
                            state_q <= ST_HELD;
                        end else begin
                            hcnt_q <= hcnt_q + 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (fall) begin
                            hcnt_q  <= '0;
                            state_q <= ST_IDLE;
                        end else if (RPT_EN) begin
                            if (hcnt_q == RPT_LAST) begin
                                repeat_q <= 1'b1;
                                hcnt_q   <= '0;
                            end else begin
                                hcnt_q <= hcnt_q + 1'b1;
                            end
                        end else begin
                            // Repeat disabled: counter parks until release.
                            hcnt_q <= hcnt_q;
                        end
                    end
                    default: begin
                        hcnt_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end

        assign level_o[g]   = level_q;
        assign press_o[g]   = press_q;
        assign release_o[g] = release_q;
        assign hold_o[g]    = hold_q;
        assign repeat_o[g]  = repeat_q;
    end

endmodule
